// File: rtl/ks_pkg.sv
// Shared constants and types for the Kogge-Stone subtractor pipeline.
// Result flags are built only when KS_SUB_FLAGS_EN is defined.
package ks_pkg;

    localparam int KS_W     = 16;
    localparam int KS_LOG2W = 4;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

endpackage

// File: rtl/ks_prefix_level.sv
// One Kogge-Stone level: black cells at i >= SPAN, pass-through below.
module ks_prefix_level
    import ks_pkg::*;
#(
    parameter int SPAN = 1
) (
    input  pg_t [KS_W-1:0] pg_i,
    output pg_t [KS_W-1:0] pg_o
);

    always_comb begin
        pg_o = pg_i;
        for (int i = SPAN; i < KS_W; i++) begin
            pg_o[i].g = pg_i[i].g | (pg_i[i].p & pg_i[i-SPAN].g);
            pg_o[i].p = pg_i[i].p & pg_i[i-SPAN].p;
        end
    end

endmodule

// File: rtl/ks_sub_pipe.sv
// 3-stage Kogge-Stone subtractor A - B - bin with a global stall enable.
// Define KS_SUB_FLAGS_EN to add registered zero/neg/ovf result flags.
module ks_sub_pipe
    import ks_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [KS_W-1:0] A,
    input  logic [KS_W-1:0] B,
    input  logic            bin,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [KS_W-1:0] diff,
    output logic            bout,
    output logic            out_valid,
`ifdef KS_SUB_FLAGS_EN
    output logic            zero,
    output logic            neg,
    output logic            ovf,
`endif
    input  logic            out_ready
);

    logic en;

    logic [KS_W-1:0] p1_d, p1_q, g1_d, g1_q;
    logic            c01_d, c01_q, v1_d, v1_q;

    pg_t [KS_W-1:0]  pg_l0, pg_l1, pg_l2, pg_l3, pg_l4;
    pg_t [KS_W-1:0]  pg2_d, pg2_q;
    logic [KS_W-1:0] p2_d, p2_q;
    logic            c02_d, c02_q, v2_d, v2_q;

    logic [KS_W-1:0] cy;
    logic [KS_W-1:0] diff_d, diff_q;
    logic            bout_d, bout_q, ov_d, ov_q;

`ifdef KS_SUB_FLAGS_EN
    logic a1_d, a1_q, b1_d, b1_q, a2_d, a2_q, b2_d, b2_q;
    logic zero_d, zero_q, neg_d, neg_q, ovf_d, ovf_q;
`endif

    assign en        = ~ov_q | out_ready;
    assign in_ready  = en;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign out_valid = ov_q;
`ifdef KS_SUB_FLAGS_EN
    assign zero = zero_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;
`endif

    ks_prefix_level #(.SPAN(1)) u_lvl1 (.pg_i(pg_l0), .pg_o(pg_l1));
    ks_prefix_level #(.SPAN(2)) u_lvl2 (.pg_i(pg_l1), .pg_o(pg_l2));
    ks_prefix_level #(.SPAN(4)) u_lvl3 (.pg_i(pg2_q), .pg_o(pg_l3));
    ks_prefix_level #(.SPAN(8)) u_lvl4 (.pg_i(pg_l3), .pg_o(pg_l4));

    always_comb begin
        p1_d  = A ^ ~B;
        g1_d  = A & ~B;
        c01_d = ~bin;
        v1_d  = in_valid;

        for (int i = 0; i < KS_W; i++) begin
            pg_l0[i].p = p1_q[i];
            pg_l0[i].g = g1_q[i];
        end
        pg2_d = pg_l2;
        p2_d  = p1_q;
        c02_d = c01_q;
        v2_d  = v1_q;

        // carry-in joins late: c[i+1] = G[i:0] | P[i:0] & c0
        for (int i = 0; i < KS_W; i++) begin
            cy[i] = pg_l4[i].g | (pg_l4[i].p & c02_q);
        end
        diff_d = p2_q ^ {cy[KS_W-2:0], c02_q};
        bout_d = ~cy[KS_W-1];
        ov_d   = v2_q;

`ifdef KS_SUB_FLAGS_EN
        a1_d   = A[KS_W-1];
        b1_d   = B[KS_W-1];
        a2_d   = a1_q;
        b2_d   = b1_q;
        zero_d = (diff_d == '0);
        neg_d  = diff_d[KS_W-1];
        ovf_d  = (a2_q != b2_q) & (diff_d[KS_W-1] != a2_q);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_q   <= '0;
            g1_q   <= '0;
            c01_q  <= 1'b0;
            v1_q   <= 1'b0;
            pg2_q  <= '0;
            p2_q   <= '0;
            c02_q  <= 1'b0;
            v2_q   <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ov_q   <= 1'b0;
`ifdef KS_SUB_FLAGS_EN
            a1_q   <= 1'b0;
            b1_q   <= 1'b0;
            a2_q   <= 1'b0;
            b2_q   <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
`endif
        end else if (en) begin
            p1_q   <= p1_d;
            g1_q   <= g1_d;
            c01_q  <= c01_d;
            v1_q   <= v1_d;
            pg2_q  <= pg2_d;
            p2_q   <= p2_d;
            c02_q  <= c02_d;
            v2_q   <= v2_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
            ov_q   <= ov_d;
`ifdef KS_SUB_FLAGS_EN
            a1_q   <= a1_d;
            b1_q   <= b1_d;
            a2_q   <= a2_d;
            b2_q   <= b2_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
            ovf_q  <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_ks_sub_pipe.sv
// Bench for ks_sub_pipe: directed vectors plus a 3-deep occupancy model.
module tb_ks_sub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] A = '0, B = '0;
    logic        bin = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, bout, out_valid;
    logic [15:0] diff;
`ifdef KS_SUB_FLAGS_EN
    logic        zero, neg, ovf;
`endif

    ks_sub_pipe dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .bin(bin),
        .in_valid(in_valid), .in_ready(in_ready),
        .diff(diff), .bout(bout), .out_valid(out_valid),
`ifdef KS_SUB_FLAGS_EN
        .zero(zero), .neg(neg), .ovf(ovf),
`endif
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int got   = 0;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        b;
        logic        z, n, o;
    } res_t;

    res_t slot [3];
    logic m_en;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic res_t ref_sub(input logic [15:0] a, input logic [15:0] b,
                                     input logic bi);
        res_t r;
        int   s;
        s   = int'(a) - int'(b) - int'(bi);
        r.v = 1'b1;
        r.d = 16'(s & 32'hFFFF);
        r.b = (s < 0);
        r.z = (r.d == 16'h0);
        r.n = r.d[15];
        r.o = (a[15] != b[15]) && (r.d[15] != a[15]);
        return r;
    endfunction

    // Compare process: the pipe is 3 slots that all advance when en is high.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) slot[i].v = 1'b0;
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_in_ready", 32'(in_ready), 1);
            chk("rst_diff", 32'(diff), 0);
            chk("rst_bout", 32'(bout), 0);
        end else begin
            m_en = !slot[2].v || out_ready;
            chk("in_ready", 32'(in_ready), 32'(m_en));
            chk("out_valid", 32'(out_valid), 32'(slot[2].v));
            if (slot[2].v) begin
                chk("diff", 32'(diff), 32'(slot[2].d));
                chk("bout", 32'(bout), 32'(slot[2].b));
`ifdef KS_SUB_FLAGS_EN
                chk("zero", 32'(zero), 32'(slot[2].z));
                chk("neg", 32'(neg), 32'(slot[2].n));
                chk("ovf", 32'(ovf), 32'(slot[2].o));
`endif
                if (out_ready) got++;
            end
            if (m_en) begin
                slot[2] = slot[1];
                slot[1] = slot[0];
                if (in_valid) slot[0] = ref_sub(A, B, bin);
                else slot[0].v = 1'b0;
            end
        end
    end

    task automatic run_one(input logic [15:0] a, input logic [15:0] b,
                           input logic bi, input logic [15:0] ed,
                           input logic eb, input logic ez,
                           input logic en_, input logic eo);
        int n;
        A = a; B = b; bin = bi; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 3);
        chk("vec_diff", 32'(diff), 32'(ed));
        chk("vec_bout", 32'(bout), 32'(eb));
`ifdef KS_SUB_FLAGS_EN
        chk("vec_zero", 32'(zero), 32'(ez));
        chk("vec_neg", 32'(neg), 32'(en_));
        chk("vec_ovf", 32'(ovf), 32'(eo));
`else
        if (ez & en_ & eo) n = 0;
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t        pin;
        int          idx, cyc, g0;
        logic        acc;
        logic [15:0] held;
        logic [15:0] corner [6];

        corner = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFE};

        pin = ref_sub(16'hFFFF, 16'hFFFF, 1'b1);
        chk("model_d", 32'(pin.d), 32'hFFFF);
        chk("model_b", 32'(pin.b), 1);
        pin = ref_sub(16'h0010, 16'h0001, 1'b1);
        chk("model_d2", 32'(pin.d), 32'h000E);

        #2;
        chk("rst_in_ready_t0", 32'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_one(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        run_one(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        run_one(16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_one(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
        run_one(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);

        // 8 back-to-back operands with a 3-cycle output stall
        g0 = got; idx = 0; cyc = 0; held = '0;
        while (idx < 8 && cyc < 40) begin
            cyc++;
            out_ready = !(cyc >= 4 && cyc <= 6);
            A = 16'(idx * 16'h1001 + 16'h0100);
            B = 16'(idx * 16'h0311);
            bin = idx[0];
            in_valid = 1'b1;
            @(negedge clk);
            acc = in_ready;
            if (!out_ready) begin
                chk("stall_in_ready", 32'(in_ready), 0);
                chk("stall_out_valid", 32'(out_valid), 1);
                if (cyc == 4) held = diff;
                else chk("stall_frozen", 32'(diff), 32'(held));
            end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("stall_count", 32'(got - g0), 8);

        // reset with two operands in flight
        g0 = got;
        A = 16'h00AA; B = 16'h0011; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        A = 16'h0F00; B = 16'h00F0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("inflight_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(out_valid), 0);
        chk("rst_async_ready", 32'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("no_stale", 32'(got - g0), 0);
        run_one(16'h0100, 16'h0001, 1'b1, 16'h00FE, 1'b0, 1'b0, 1'b0, 1'b0);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            A = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 5)]
                                            : 16'($urandom);
            B = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 5)]
                                            : 16'($urandom);
            bin = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
